// File: rtl/alarm_ring_ctrl_pkg.sv
// ============================================================================
// Module   : alarm_ring_ctrl_pkg
// Brief    : State encoding, default timing constants and width helpers
// Revision : 1.0
// ============================================================================
`default_nettype none

package alarm_ring_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    localparam int DEF_TICK_DIV    = 100_000_000;
    localparam int DEF_RING_SECS   = 60;
    localparam int DEF_SNOOZE_SECS = 300;
    localparam int DEF_MAX_SNOOZE  = 3;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_sec_timer.sv
// ============================================================================
// Module   : alarm_sec_timer
// Brief    : Tick divider plus second counter with clear and timeout detect
// Revision : 1.0
// ============================================================================
`default_nettype none

module alarm_sec_timer
    import alarm_ring_ctrl_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int MAX_SECS = DEF_SNOOZE_SECS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic [cnt_width(MAX_SECS)-1:0]   last_sec,
    output logic                             timeout
);

    localparam int TW = cnt_width(TICK_DIV);
    localparam int SW = cnt_width(MAX_SECS);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] r_tick;
    logic [SW-1:0] r_sec;
    logic          w_tick_wrap;

    assign w_tick_wrap = (r_tick == TICK_LAST);
    assign timeout     = w_tick_wrap && (r_sec == last_sec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= '0;
            r_sec  <= '0;
        end else if (clr) begin
            r_tick <= '0;
            r_sec  <= '0;
        end else if (w_tick_wrap) begin
            r_tick <= '0;
            r_sec  <= timeout ? '0 : r_sec + 1'b1;
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alarm_ring_ctrl.sv
// ============================================================================
// Module   : alarm_ring_ctrl
// Brief    : Gates the melody to the speaker while an alarm rings, with snooze
// Revision : 1.0
// ============================================================================
`default_nettype none

module alarm_ring_ctrl
    import alarm_ring_ctrl_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int RING_SECS   = DEF_RING_SECS,
    parameter int SNOOZE_SECS = DEF_SNOOZE_SECS,
    parameter int MAX_SNOOZE  = DEF_MAX_SNOOZE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tone_in,
    input  logic       alarm_hit,
    input  logic       alarm_en,
    input  logic       stop,
    input  logic       snooze,
    output logic       spk_out,
    output logic       ringing,
    output logic       snoozed,
    output logic [1:0] snooze_cnt
);

    localparam int MAX_SECS = max_int(RING_SECS, SNOOZE_SECS);
    localparam int SW       = cnt_width(MAX_SECS);
    localparam logic [SW-1:0] RING_LAST   = SW'(RING_SECS - 1);
    localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SECS - 1);
    localparam logic [1:0]    SNOOZE_MAX  = 2'(MAX_SNOOZE);

    state_t        r_state;
    state_t        w_next;
    logic          r_hit_q;
    logic [1:0]    r_snooze_cnt;
    logic          r_spk;
    logic          w_trigger;
    logic          w_timeout;
    logic          w_tmr_clr;
    logic          w_cnt_clr;
    logic          w_cnt_inc;
    logic [SW-1:0] w_last_sec;

    assign w_trigger  = alarm_hit & ~r_hit_q;
    assign w_last_sec = (r_state == SNOOZE) ? SNOOZE_LAST : RING_LAST;
    // Timer restarts on every state change and stays parked while idle.
    assign w_tmr_clr  = (w_next != r_state) || (r_state == IDLE);

    alarm_sec_timer #(
        .TICK_DIV (TICK_DIV),
        .MAX_SECS (MAX_SECS)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_tmr_clr),
        .last_sec (w_last_sec),
        .timeout  (w_timeout)
    );

    always_comb begin
        w_next    = r_state;
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_trigger && alarm_en) begin
                    w_next    = RING;
                    w_cnt_clr = 1'b1;
                end
            end
            RING: begin
                if (!alarm_en || stop) begin
                    w_next = IDLE;
                end else if (snooze && (r_snooze_cnt < SNOOZE_MAX)) begin
                    w_next    = SNOOZE;
                    w_cnt_inc = 1'b1;
                end else if (w_timeout) begin
                    w_next = IDLE;
                end
            end
            SNOOZE: begin
                if (!alarm_en || stop) begin
                    w_next = IDLE;
                end else if (w_timeout) begin
                    w_next = RING;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_hit_q      <= 1'b1;
            r_snooze_cnt <= 2'd0;
            r_spk        <= 1'b0;
        end else begin
            r_state <= w_next;
            r_hit_q <= alarm_hit;
            r_spk   <= tone_in & (r_state == RING);
            if (w_cnt_clr) begin
                r_snooze_cnt <= 2'd0;
            end else if (w_cnt_inc) begin
                r_snooze_cnt <= r_snooze_cnt + 2'd1;
            end
        end
    end

    assign spk_out    = r_spk;
    assign ringing    = (r_state == RING);
    assign snoozed    = (r_state == SNOOZE);
    assign snooze_cnt = r_snooze_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alarm_ring_ctrl.sv
// ============================================================================
// Module   : tb_alarm_ring_ctrl
// Brief    : Directed self-checking bench for alarm_ring_ctrl
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alarm_ring_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tone_in;
    logic       alarm_hit;
    logic       alarm_en;
    logic       stop;
    logic       snooze;
    logic       spk_out;
    logic       ringing;
    logic       snoozed;
    logic [1:0] snooze_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int n;

    alarm_ring_ctrl #(
        .TICK_DIV    (4),
        .RING_SECS   (3),
        .SNOOZE_SECS (2),
        .MAX_SNOOZE  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tone_in    (tone_in),
        .alarm_hit  (alarm_hit),
        .alarm_en   (alarm_en),
        .stop       (stop),
        .snooze     (snooze),
        .spk_out    (spk_out),
        .ringing    (ringing),
        .snoozed    (snoozed),
        .snooze_cnt (snooze_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tone_in = 1'b0;
        forever begin
            @(posedge clk);
            #2 tone_in = ~tone_in;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic trigger_alarm();
        alarm_hit = 1'b0;
        step();
        alarm_hit = 1'b1;
        step();
    endtask

    // Counts consecutive samples (including the current one) with the flag high.
    task automatic count_high(input bit use_snz, output int cnt);
        cnt = 0;
        while (((use_snz ? snoozed : ringing) === 1'b1) && cnt < 100) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; alarm_hit = 1'b1; alarm_en = 1'b1; stop = 1'b0; snooze = 1'b0;
        step(); step();
        chk_eq("rst_ringing", ringing, 0);
        chk_eq("rst_snoozed", snoozed, 0);
        chk_eq("rst_spk", spk_out, 0);
        chk_eq("rst_cnt", snooze_cnt, 0);
        rst_n = 1'b1;
        step(); step(); step();
        chk_eq("no_trig_level_at_release", ringing, 0);

        // Plain ring to timeout
        trigger_alarm();
        chk_eq("ring_start", ringing, 1);
        chk_eq("spk_first_cycle", spk_out, 0);
        step();
        chk_eq("spk_track_a", spk_out, tone_in);
        step();
        chk_eq("spk_track_b", spk_out, tone_in);
        count_high(1'b0, n);
        chk_eq("ring_len", n + 2, 12);
        step();
        chk_eq("spk_off_after_ring", spk_out, 0);
        chk_eq("cnt_after_timeout", snooze_cnt, 0);

        // Snooze at cycle 3, then a second snooze, then one beyond the limit
        trigger_alarm();
        step(); step();
        snooze = 1'b1; step(); snooze = 1'b0;
        chk_eq("snz1_snoozed", snoozed, 1);
        chk_eq("snz1_ringing", ringing, 0);
        chk_eq("snz1_cnt", snooze_cnt, 1);
        count_high(1'b1, n);
        chk_eq("snz1_len", n, 8);
        chk_eq("re_ring1", ringing, 1);
        snooze = 1'b1; step(); snooze = 1'b0;
        chk_eq("snz2_snoozed", snoozed, 1);
        chk_eq("snz2_cnt", snooze_cnt, 2);
        count_high(1'b1, n);
        chk_eq("snz2_len", n, 8);
        chk_eq("re_ring2", ringing, 1);
        snooze = 1'b1; step(); snooze = 1'b0;
        chk_eq("snz_limit_ignored", snoozed, 0);
        chk_eq("snz_limit_cnt", snooze_cnt, 2);
        count_high(1'b0, n);
        chk_eq("ring_len_at_limit", n + 1, 12);
        chk_eq("cnt_held_in_idle", snooze_cnt, 2);

        // Stop and snooze together: stop wins
        trigger_alarm();
        chk_eq("cnt_cleared_on_trigger", snooze_cnt, 0);
        step();
        stop = 1'b1; snooze = 1'b1; step(); stop = 1'b0; snooze = 1'b0;
        chk_eq("stop_snz_ringing", ringing, 0);
        chk_eq("stop_snz_snoozed", snoozed, 0);
        chk_eq("stop_snz_cnt", snooze_cnt, 0);

        // alarm_en dropped during snooze
        trigger_alarm();
        snooze = 1'b1; step(); snooze = 1'b0;
        chk_eq("en_test_snoozed", snoozed, 1);
        step();
        alarm_en = 1'b0; step();
        chk_eq("en_drop_snoozed", snoozed, 0);
        chk_eq("en_drop_ringing", ringing, 0);
        chk_eq("en_drop_cnt_held", snooze_cnt, 1);

        // Trigger while disarmed is ignored
        trigger_alarm();
        chk_eq("disarmed_no_ring", ringing, 0);
        alarm_en = 1'b1; step();
        chk_eq("arm_no_ring", ringing, 0);

        // Timeout coinciding with snooze goes to snooze
        trigger_alarm();
        for (int i = 0; i < 11; i++) step();
        chk_eq("last_ring_cycle", ringing, 1);
        snooze = 1'b1; step(); snooze = 1'b0;
        chk_eq("timeout_snz_snoozed", snoozed, 1);
        chk_eq("timeout_snz_cnt", snooze_cnt, 1);
        stop = 1'b1; step(); stop = 1'b0;
        chk_eq("stop_in_snooze", snoozed, 0);

        // Asynchronous reset mid-ring
        trigger_alarm();
        snooze = 1'b1; step(); snooze = 1'b0;
        count_high(1'b1, n);
        step();
        chk_eq("pre_rst_ringing", ringing, 1);
        chk_eq("pre_rst_cnt", snooze_cnt, 1);
        #1 rst_n = 1'b0;
        #1;
        chk_eq("async_rst_ringing", ringing, 0);
        chk_eq("async_rst_spk", spk_out, 0);
        chk_eq("async_rst_cnt", snooze_cnt, 0);
        chk_eq("async_rst_snoozed", snoozed, 0);
        #2 rst_n = 1'b1;
        step(); step(); step(); step();
        chk_eq("post_rst_no_ring", ringing, 0);
        trigger_alarm();
        chk_eq("post_rst_new_edge", ringing, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
